axi_frame_reader: RTL and testbench

Stream reader placed on the output side of the channelizer's AXI FIFOs. It pops words from an upstream FIFO's master port and re-emits them as framed packets of a programmable length, asserting `m_axis_tlast` on the final word of each frame. An optional fixed idle gap is inserted between frames. A frame counter is exposed for status and debug.

---
 rtl/axi_frame_reader_pkg.sv | 17 +
 rtl/axi_frame_reader_skid.sv | 72 +++++++
 rtl/axi_frame_reader.sv | 116 +++++++++++
 tb/tb_axi_frame_reader.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/axi_frame_reader_pkg.sv
// Shared channelizer definitions: FSM state encoding and the frame-length
// convention where a programmed length of zero means the maximum (2^LEN_WIDTH).
package axi_frame_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // Words in a frame for a programmed length; zero selects 2^len_width.
  function automatic int unsigned frame_words(input int unsigned len,
                                              input int unsigned len_width);
    return (len == 0) ? (32'd1 << len_width) : len;
  endfunction

endpackage

// File: rtl/axi_frame_reader_skid.sv
// Two-entry output stage (output register plus one skid register) with a
// registered upstream ready; accept_en lets the owner hold ready low.
module axi_skid_buffer #(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             async_reset_n,
  input  logic             accept_en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             in_ready_q;
  logic             push;
  logic             out_free;

  assign push     = in_valid && in_ready_q;
  assign out_free = !out_valid_q || out_ready;

  // Ready is registered from the next skid occupancy, so a push never meets a
  // full skid register and the skid drains before new words are taken.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (out_free) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (push) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (push) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
  end

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      in_ready_q   <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      in_ready_q   <= !skid_valid_d && accept_en;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: rtl/axi_frame_reader.sv
// Frames an upstream word stream into packets of frame_len words with tlast on
// the final word, an optional idle gap after each frame, and a frame counter.
module axi_frame_reader
  import axi_frame_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int GAP_CYCLES = 0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  async_reset_n,
  input  logic [LEN_WIDTH-1:0]  frame_len,
  input  logic                  s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  output logic                  s_axis_tready,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [CNT_WIDTH-1:0]  frame_cnt,
  output logic                  in_frame
);

  // Handshake: a word moves on a rising edge where valid && ready on that side;
  // a valid output holds data, tlast and valid until it is taken.

  localparam bit       HAS_GAP  = (GAP_CYCLES > 0);
  localparam bit [7:0] GAP_LOAD = HAS_GAP ? 8'(GAP_CYCLES - 1) : 8'd0;

  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] words_left_q, words_left_d;
  logic [7:0]           gap_cnt_q, gap_cnt_d;
  logic [LEN_WIDTH-1:0] first_left;
  logic                 in_xfer;
  logic                 in_last;
  logic [DATA_WIDTH:0]  out_bus;
  logic [CNT_WIDTH-1:0] frame_cnt_q;

  // Words still to come after the first one of a frame, from the live frame_len.
  assign first_left = LEN_WIDTH'(frame_words(32'(frame_len), LEN_WIDTH) - 32'd1);
  assign in_xfer    = s_axis_tvalid && s_axis_tready;

  always_comb begin
    state_d      = state_q;
    words_left_d = words_left_q;
    gap_cnt_d    = gap_cnt_q;
    in_last      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_xfer) begin
          words_left_d = first_left;
          if (first_left == '0) begin
            in_last   = 1'b1;
            state_d   = HAS_GAP ? ST_GAP : ST_IDLE;
            gap_cnt_d = GAP_LOAD;
          end else begin
            state_d = ST_FRAME;
          end
        end
      end
      ST_FRAME: begin
        if (in_xfer) begin
          words_left_d = words_left_q - 1'b1;
          if (words_left_q == LEN_WIDTH'(1)) begin
            in_last   = 1'b1;
            state_d   = HAS_GAP ? ST_GAP : ST_IDLE;
            gap_cnt_d = GAP_LOAD;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == 8'd0) state_d = ST_IDLE;
        else gap_cnt_d = gap_cnt_q - 8'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      state_q      <= ST_IDLE;
      words_left_q <= '0;
      gap_cnt_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      words_left_q <= words_left_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end

  axi_skid_buffer #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_skid (
    .clk           (clk),
    .async_reset_n (async_reset_n),
    .accept_en     (state_d != ST_GAP),
    .in_valid      (s_axis_tvalid),
    .in_data       ({in_last, s_axis_tdata}),
    .in_ready      (s_axis_tready),
    .out_valid     (m_axis_tvalid),
    .out_data      (out_bus),
    .out_ready     (m_axis_tready)
  );

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) frame_cnt_q <= '0;
    else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) frame_cnt_q <= frame_cnt_q + 1'b1;
  end

  assign m_axis_tdata = out_bus[DATA_WIDTH-1:0];
  assign m_axis_tlast = out_bus[DATA_WIDTH];
  assign frame_cnt    = frame_cnt_q;
  assign in_frame     = (state_q == ST_FRAME);

endmodule

// File: tb/tb_axi_frame_reader.sv
// Bench for axi_frame_reader: three instances (no gap, 2-cycle gap, 2-bit length)
// driven from a scenario table, hand sequences and randomized streams.
module tb_axi_frame_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [7:0]  frame_len [3];
  logic        s_tvalid  [3];
  logic [31:0] s_tdata   [3];
  logic        s_tready  [3];
  logic        m_tvalid  [3];
  logic [31:0] m_tdata   [3];
  logic        m_tlast   [3];
  logic        m_tready  [3];
  logic [15:0] frame_cnt [3];
  logic        in_frame  [3];

  axi_frame_reader #(.DATA_WIDTH(32), .LEN_WIDTH(8), .GAP_CYCLES(0), .CNT_WIDTH(16)) dut_g0 (
    .clk(clk), .async_reset_n(rst_n), .frame_len(frame_len[0]),
    .s_axis_tvalid(s_tvalid[0]), .s_axis_tdata(s_tdata[0]), .s_axis_tready(s_tready[0]),
    .m_axis_tvalid(m_tvalid[0]), .m_axis_tdata(m_tdata[0]), .m_axis_tlast(m_tlast[0]),
    .m_axis_tready(m_tready[0]), .frame_cnt(frame_cnt[0]), .in_frame(in_frame[0]));

  axi_frame_reader #(.DATA_WIDTH(32), .LEN_WIDTH(8), .GAP_CYCLES(2), .CNT_WIDTH(16)) dut_g2 (
    .clk(clk), .async_reset_n(rst_n), .frame_len(frame_len[1]),
    .s_axis_tvalid(s_tvalid[1]), .s_axis_tdata(s_tdata[1]), .s_axis_tready(s_tready[1]),
    .m_axis_tvalid(m_tvalid[1]), .m_axis_tdata(m_tdata[1]), .m_axis_tlast(m_tlast[1]),
    .m_axis_tready(m_tready[1]), .frame_cnt(frame_cnt[1]), .in_frame(in_frame[1]));

  axi_frame_reader #(.DATA_WIDTH(32), .LEN_WIDTH(2), .GAP_CYCLES(0), .CNT_WIDTH(16)) dut_w2 (
    .clk(clk), .async_reset_n(rst_n), .frame_len(frame_len[2][1:0]),
    .s_axis_tvalid(s_tvalid[2]), .s_axis_tdata(s_tdata[2]), .s_axis_tready(s_tready[2]),
    .m_axis_tvalid(m_tvalid[2]), .m_axis_tdata(m_tdata[2]), .m_axis_tlast(m_tlast[2]),
    .m_axis_tready(m_tready[2]), .frame_cnt(frame_cnt[2]), .in_frame(in_frame[2]));

  int total = 0;
  int bad   = 0;

  // Reference model state: expected {tlast, data} queue and frame position.
  logic [32:0] exp_q[$];
  int          lw [3] = '{8, 8, 2};
  int          sent, cyc, pos, cur_len, model_frames;
  int          first_acc, last_acc, first_out;
  logic        prev_stall;
  logic [32:0] prev_val;

  typedef struct {
    int inst;
    int len;
    int chg_at;
    int chg_len;
    int n;
    int val_pct;
    int rdy_pct;
    int exp_frames;
    int exp_span;
  } vec_t;
  vec_t tbl [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    pos = 0; cur_len = 1; model_frames = 0; cyc = 0; sent = 0;
    first_acc = -1; last_acc = -1; first_out = -1; prev_stall = 1'b0; prev_val = '0;
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 3; i++) begin
      s_tvalid[i] = 1'b0; s_tdata[i] = '0; m_tready[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    clear_model();
  endtask

  // One clock: evaluate both handshakes at the negedge, then step past the edge.
  task automatic cycle(input int k);
    logic [32:0] e;
    int          fl;
    @(negedge clk);
    if (m_tvalid[k] && first_out < 0) first_out = cyc;
    if (prev_stall) check("hold", {m_tlast[k], m_tdata[k]}, prev_val);
    prev_stall = m_tvalid[k] && !m_tready[k];
    prev_val   = {m_tlast[k], m_tdata[k]};
    if (m_tvalid[k] && m_tready[k]) begin
      if (exp_q.size() == 0) check("spurious_out", {m_tlast[k], m_tdata[k]}, 64'hDEAD);
      else begin
        e = exp_q.pop_front();
        check("out_word", {m_tlast[k], m_tdata[k]}, e);
      end
    end
    if (s_tvalid[k] && s_tready[k]) begin
      if (pos == 0) begin
        fl = int'(frame_len[k]) % (1 << lw[k]);
        cur_len = (fl == 0) ? (1 << lw[k]) : fl;
      end
      exp_q.push_back({pos == cur_len - 1, s_tdata[k]});
      if (pos == cur_len - 1) begin
        pos = 0; model_frames++;
      end else pos++;
      if (first_acc < 0) first_acc = cyc;
      last_acc = cyc;
      sent++;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic run_stream(input int k, input int n, input int val, input int rdy,
                            input int chg_at, input int chg_len);
    int budget = 0;
    while (!(sent >= n && exp_q.size() == 0) && budget < 20000) begin
      if (chg_at >= 0 && sent == chg_at) frame_len[k] = 8'(chg_len);
      s_tvalid[k] = (sent < n) && ($urandom_range(0, 99) < val);
      s_tdata[k]  = 32'hA500_0000 ^ {8'(k), 24'(sent)};
      m_tready[k] = ($urandom_range(0, 99) < rdy);
      cycle(k);
      budget++;
    end
    s_tvalid[k] = 1'b0;
    m_tready[k] = 1'b0;
    check("drain", 64'(exp_q.size() + (n - sent)), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 3; i++) frame_len[i] = 8'd4;
    idle_inputs();
    clear_model();

    // Reset values while reset is held.
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("rst_s_tready", 64'(s_tready[i]), 64'd0);
      check("rst_m_tvalid", 64'(m_tvalid[i]), 64'd0);
      check("rst_m_tdata",  64'(m_tdata[i]),  64'd0);
      check("rst_m_tlast",  64'(m_tlast[i]),  64'd0);
      check("rst_frame_cnt", 64'(frame_cnt[i]), 64'd0);
      check("rst_in_frame", 64'(in_frame[i]), 64'd0);
    end
    @(negedge clk) rst_n = 1'b1;
    check("ready_before_edge", 64'(s_tready[0]), 64'd0);
    @(posedge clk); #1;
    check("ready_after_edge", 64'(s_tready[0]), 64'd1);

    //             inst len chg_at chg_len  n  val rdy frames span
    tbl[0] = '{0,   4,  -1,  0,  12, 100, 100,  3,  11};
    tbl[1] = '{1,   3,  -1,  0,   6, 100, 100,  2,   7};
    tbl[2] = '{0,   5,  -1,  0,  20, 100,  50,  4,  -1};
    tbl[3] = '{2,   0,  -1,  0,   8, 100, 100,  2,   7};
    tbl[4] = '{2,   1,  -1,  0,   5, 100, 100,  5,   4};
    tbl[5] = '{0,   4,   2,  2,   8, 100, 100,  3,   7};
    tbl[6] = '{0,   0,  -1,  0, 512, 100, 100,  2, 511};
    tbl[7] = '{1,   1,  -1,  0,   4, 100, 100,  4,   9};
    tbl[8] = '{0,   7,  -1,  0,  35,  60,  70,  5,  -1};
    tbl[9] = '{1,   5,  -1,  0,  15,  80,  40,  3,  -1};

    foreach (tbl[i]) begin
      do_reset();
      frame_len[tbl[i].inst] = 8'(tbl[i].len);
      run_stream(tbl[i].inst, tbl[i].n, tbl[i].val_pct, tbl[i].rdy_pct,
                 tbl[i].chg_at, tbl[i].chg_len);
      check("frame_cnt", 64'(frame_cnt[tbl[i].inst]), 64'(tbl[i].exp_frames));
      check("model_frames", 64'(model_frames), 64'(tbl[i].exp_frames));
      check("latency", 64'(first_out - first_acc), 64'd1);
      if (tbl[i].exp_span >= 0)
        check("accept_span", 64'(last_acc - first_acc), 64'(tbl[i].exp_span));
    end

    // Reset in the middle of a 6-word frame, then a fresh full frame.
    do_reset();
    frame_len[0] = 8'd6;
    for (int w = 0; w < 3; w++) begin
      s_tvalid[0] = 1'b1;
      s_tdata[0]  = 32'h0000_0C00 + 32'(w);
      m_tready[0] = 1'b1;
      cycle(0);
    end
    s_tvalid[0] = 1'b0;
    check("in_frame_mid", 64'(in_frame[0]), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_m_tvalid", 64'(m_tvalid[0]), 64'd0);
    check("mid_rst_m_tdata",  64'(m_tdata[0]),  64'd0);
    check("mid_rst_m_tlast",  64'(m_tlast[0]),  64'd0);
    check("mid_rst_s_tready", 64'(s_tready[0]), 64'd0);
    check("mid_rst_in_frame", 64'(in_frame[0]), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    clear_model();
    run_stream(0, 6, 100, 100, -1, 0);
    check("post_rst_frame_cnt", 64'(frame_cnt[0]), 64'd1);

    // Randomized streams with random lengths and a mid-stream length change.
    for (int t = 0; t < 4; t++) begin
      int k;
      k = (t % 2 == 0) ? 0 : 1;
      do_reset();
      frame_len[k] = 8'($urandom_range(1, 9));
      run_stream(k, $urandom_range(20, 60), 70, 60, $urandom_range(3, 10), $urandom_range(1, 6));
      check("rand_frame_cnt", 64'(frame_cnt[k]), 64'(model_frames % 65536));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
